// File: rtl/spio_rx_ctrl.sv
// Receive sequencer for a framed serial input: start, WIDTH data bits (LSB first),
// optional even parity, stop. Owns the shift register and presents words on valid/ready.
module spio_rx_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sin,
    input  logic             bit_tick,
    input  logic             err_clr,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             shift_en,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             pend_q, pend_d;
    logic             fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
    logic             good_stop, fe_ev, pe_ev, ov_ev, load;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        pend_d    = pend_q;
        good_stop = 1'b0;
        fe_ev     = 1'b0;
        if (bit_tick) begin
            case (state_q)
                IDLE: if (!sin) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
                DATA: begin
                    sh_d  = {sin, sh_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1))
                        state_d = PARITY_EN ? PARITY : STOP;
                end
                PARITY: begin
                    pend_d  = (^sh_q) ^ sin;
                    state_d = STOP;
                end
                STOP: begin
                    good_stop = sin;
                    fe_ev     = !sin;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // A good word either lands in dout or, if dout is still held, is dropped.
        pe_ev = good_stop && pend_q;
        ov_ev = good_stop && valid_q && !dout_ready;
        load  = good_stop && (!valid_q || dout_ready);

        dout_d  = dout_q;
        valid_d = valid_q;
        if (load) begin
            dout_d  = sh_q;
            valid_d = 1'b1;
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end

        // New error events take priority over a simultaneous clear.
        fe_d = fe_ev | (fe_q & ~err_clr);
        pe_d = pe_ev | (pe_q & ~err_clr);
        ov_d = ov_ev | (ov_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            ov_q    <= ov_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign shift_en   = (state_q == DATA) && bit_tick;
    assign busy       = (state_q != IDLE);
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign overrun    = ov_q;
endmodule

// File: tb/tb_spio_rx_ctrl.sv
// Bench for spio_rx_ctrl: instance 0 without parity, instance 1 with even parity,
// both compared every cycle against a frame-level reference model.
module tb_spio_rx_ctrl;
    logic       clk = 1'b0;
    logic       clear;
    logic       sin[2], tick[2], eclr[2], rdy[2];
    logic [3:0] dout[2];
    logic       valid[2], shf[2], busy[2], fe[2], pe[2], ov[2];

    logic [3:0] m_dout[2];
    logic       m_valid[2], m_fe[2], m_pe[2], m_ov[2];
    int         nvec = 0, nbad = 0;

    always #5 clk = ~clk;

    spio_rx_ctrl #(.WIDTH(4), .PARITY_EN(1'b0)) u0 (
        .clk(clk), .clear(clear), .sin(sin[0]), .bit_tick(tick[0]), .err_clr(eclr[0]),
        .dout_ready(rdy[0]), .dout(dout[0]), .dout_valid(valid[0]), .shift_en(shf[0]),
        .busy(busy[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]));

    spio_rx_ctrl #(.WIDTH(4), .PARITY_EN(1'b1)) u1 (
        .clk(clk), .clear(clear), .sin(sin[1]), .bit_tick(tick[1]), .err_clr(eclr[1]),
        .dout_ready(rdy[1]), .dout(dout[1]), .dout_valid(valid[1]), .shift_en(shf[1]),
        .busy(busy[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]));

    // Reference: what one clock edge does to the visible word/flags of instance v.
    task automatic model_edge(int v, bit stop, bit stopv, logic [3:0] w, bit pbad);
        bit good, fev, pev, oev, ld;
        if (!clear) begin
            m_dout[v] = '0; m_valid[v] = 0; m_fe[v] = 0; m_pe[v] = 0; m_ov[v] = 0;
            return;
        end
        good = stop && stopv;
        fev  = stop && !stopv;
        pev  = good && pbad;
        oev  = good && m_valid[v] && !rdy[v];
        ld   = good && (!m_valid[v] || rdy[v]);
        if (ld) begin
            m_dout[v] = w; m_valid[v] = 1;
        end else if (m_valid[v] && rdy[v]) begin
            m_valid[v] = 0;
        end
        m_fe[v] = fev || (m_fe[v] && !eclr[v]);
        m_pe[v] = pev || (m_pe[v] && !eclr[v]);
        m_ov[v] = oev || (m_ov[v] && !eclr[v]);
    endtask

    // One clock on instance u, entered and left at a falling edge.
    task automatic cyc(int u, bit t, bit s, bit stop, bit stopv, logic [3:0] w, bit pbad,
                       bit exp_shf, int busy_e);
        logic [7:0] got, exp;
        tick[u] = t; sin[u] = s;
        #1;
        nvec++;
        if (shf[u] !== exp_shf) begin
            nbad++; $display("FAIL shift_en%0d: got %b want %b", u, shf[u], exp_shf);
        end
        @(posedge clk);
        for (int v = 0; v < 2; v++) model_edge(v, (v == u) && stop, stopv, w, pbad);
        @(negedge clk);
        for (int v = 0; v < 2; v++) begin
            got = {dout[v], valid[v], fe[v], pe[v], ov[v]};
            exp = {m_dout[v], m_valid[v], m_fe[v], m_pe[v], m_ov[v]};
            nvec++;
            if (got !== exp) begin
                nbad++; $display("FAIL outs%0d {dout,vld,fe,pe,ov}: got %h want %h", v, got, exp);
            end
        end
        if (busy_e >= 0) begin
            nvec++;
            if (busy[u] !== 1'(busy_e)) begin
                nbad++; $display("FAIL busy%0d: got %b want %0d", u, busy[u], busy_e);
            end
        end
        tick[u] = 0; eclr[u] = 0;
    endtask

    task automatic idle(int u);
        cyc(u, 0, 1, 0, 1, 4'h0, 0, 0, 0);
    endtask

    // rdy_mode: 0 keep rdy, 1 random rdy/err_clr each clk, 2 rdy only on the stop tick.
    // abort_after >= 0: pulse clear once the tick of bit index abort_after has been sent.
    task automatic frame(int u, logic [3:0] w, bit pb, bit stopv, int gap, int rdy_mode,
                         int abort_after);
        bit bits[$];
        bit pbad, t, stop;
        int last, busy_e;
        bits.push_back(1'b0);
        for (int i = 0; i < 4; i++) bits.push_back(w[i]);
        if (u == 1) bits.push_back(pb);
        bits.push_back(stopv);
        last   = bits.size() - 1;
        pbad   = (u == 1) && ((($countones(w) + int'(pb)) % 2) != 0);
        busy_e = 0;
        for (int k = 0; k <= last; k++) begin
            for (int c = 0; c < gap; c++) begin
                t    = (c == 0);
                stop = t && (k == last);
                if (rdy_mode == 1) begin
                    rdy[u]  = 1'($urandom);
                    eclr[u] = ($urandom_range(0, 7) == 0);
                end else if (rdy_mode == 2) begin
                    rdy[u] = stop;
                end
                if (t) busy_e = (k == last) ? 0 : 1;
                cyc(u, t, t ? bits[k] : 1'($urandom), stop, stopv, w, pbad,
                    t && k >= 1 && k <= 4, busy_e);
            end
            if (k == abort_after) begin
                clear = 0;
                cyc(u, 0, 1, 0, 1, 4'h0, 0, 0, 0);
                clear = 1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        for (int v = 0; v < 2; v++) begin
            tick[v] = 1; sin[v] = 0;
            m_dout[v] = '0; m_valid[v] = 0; m_fe[v] = 0; m_pe[v] = 0; m_ov[v] = 0;
        end
        clear = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int v = 0; v < 2; v++) begin
            nvec++;
            if ({dout[v], valid[v], busy[v], shf[v], fe[v], pe[v], ov[v]} !== 10'h0) begin
                nbad++;
                $display("FAIL reset%0d: got %h want 000",
                         v, {dout[v], valid[v], busy[v], shf[v], fe[v], pe[v], ov[v]});
            end
            tick[v] = 0; sin[v] = 1;
        end
        clear = 1;
    endtask

    task automatic test_basic;
        rdy[0] = 1;
        frame(0, 4'hD, 0, 1, 8, 0, -1);
        nvec++;
        if (dout[0] !== 4'hD) begin nbad++; $display("FAIL basic_dout: got %h want d", dout[0]); end
    endtask

    task automatic test_frame_err;
        frame(0, 4'h2, 0, 0, 8, 0, -1);
        nvec++;
        if ({fe[0], valid[0], dout[0]} !== 6'b10_1101) begin
            nbad++; $display("FAIL frame_err: got %b want 101101", {fe[0], valid[0], dout[0]});
        end
        eclr[0] = 1;
        idle(0);
        nvec++;
        if (fe[0] !== 1'b0) begin nbad++; $display("FAIL err_clr: got %b want 0", fe[0]); end
    endtask

    task automatic test_parity;
        rdy[1] = 1;
        frame(1, 4'hD, 1, 1, 8, 0, -1);
        nvec++;
        if ({dout[1], pe[1]} !== 5'b1101_0) begin
            nbad++; $display("FAIL parity_ok: got %b want 11010", {dout[1], pe[1]});
        end
        frame(1, 4'hD, 0, 1, 8, 0, -1);
        nvec++;
        if ({dout[1], pe[1]} !== 5'b1101_1) begin
            nbad++; $display("FAIL parity_bad: got %b want 11011", {dout[1], pe[1]});
        end
        eclr[1] = 1;
        idle(1);
    endtask

    task automatic test_overrun;
        rdy[0] = 0;
        frame(0, 4'hD, 0, 1, 8, 0, -1);
        frame(0, 4'h3, 0, 1, 8, 0, -1);
        nvec++;
        if ({dout[0], valid[0], ov[0]} !== 6'b1101_11) begin
            nbad++; $display("FAIL overrun: got %b want 110111", {dout[0], valid[0], ov[0]});
        end
        rdy[0] = 1;
        idle(0);
        nvec++;
        if (valid[0] !== 1'b0) begin nbad++; $display("FAIL drain: got %b want 0", valid[0]); end
    endtask

    task automatic test_ready_on_stop;
        eclr[0] = 1;
        idle(0);
        rdy[0] = 0;
        frame(0, 4'hA, 0, 1, 8, 0, -1);
        frame(0, 4'h5, 0, 1, 8, 2, -1);
        nvec++;
        if ({dout[0], valid[0], ov[0]} !== 6'b0101_10) begin
            nbad++; $display("FAIL ready_on_stop: got %b want 010110", {dout[0], valid[0], ov[0]});
        end
        rdy[0] = 1;
        idle(0);
    endtask

    task automatic test_reset_midframe;
        rdy[0] = 0;
        frame(0, 4'h9, 0, 1, 4, 0, -1);
        frame(0, 4'h0, 0, 0, 4, 0, -1);
        frame(0, 4'h6, 0, 1, 4, 0, 2);
        nvec++;
        if ({busy[0], valid[0], fe[0], pe[0], ov[0]} !== 5'b0) begin
            nbad++;
            $display("FAIL mid_reset: got %b want 00000", {busy[0], valid[0], fe[0], pe[0], ov[0]});
        end
        rdy[0] = 1;
        frame(0, 4'h6, 0, 1, 4, 0, -1);
        nvec++;
        if (dout[0] !== 4'h6) begin nbad++; $display("FAIL post_reset: got %h want 6", dout[0]); end
    endtask

    task automatic test_back_to_back;
        rdy[0] = 1; rdy[1] = 1;
        for (int i = 0; i < 6; i++) begin
            frame(i % 2, 4'($urandom), 1'($urandom), 1, 1, 0, -1);
        end
    endtask

    task automatic test_random;
        int u;
        for (int i = 0; i < 60; i++) begin
            u = $urandom_range(0, 1);
            frame(u, 4'($urandom), 1'($urandom), $urandom_range(0, 5) != 0,
                  $urandom_range(1, 5), 1, -1);
        end
    endtask

    initial begin
        clear = 0;
        for (int v = 0; v < 2; v++) begin
            sin[v] = 1; tick[v] = 0; eclr[v] = 0; rdy[v] = 0;
        end
        @(negedge clk);
        test_reset;
        test_basic;
        test_frame_err;
        test_parity;
        test_overrun;
        test_ready_on_stop;
        test_reset_midframe;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/spio_rx_ctrl.md
Name: spio_rx_ctrl

Overview:
- Controller that sequences a serial-in/parallel-out shift register for a framed serial input: start bit, WIDTH data bits, optional even-parity bit, stop bit.
- Frame timing comes from an external bit-rate strobe. The block owns the shift register and bit counter, presents each completed word on a valid/ready handshake, and reports framing, parity and overrun errors.
- Sits between the serial pin logic and the parallel consumer in the SPIO family.

Parameters:
- WIDTH, 4, number of data bits per frame; the parallel word width (legal 2..16).
- PARITY_EN, 0, 1 = an even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk  input  1  system clock, all logic on rising edge
- clear  input  1  synchronous active-low reset, sampled on rising clk
- sin  input  1  serial data, idle high, already synchronised to clk
- bit_tick  input  1  one-clk strobe per bit period; sin is sampled only when bit_tick=1
- err_clr  input  1  one-clk pulse clearing the sticky error flags
- dout_ready  input  1  consumer accepts dout this cycle
- dout  output  WIDTH  received word, LSB = first data bit received
- dout_valid  output  1  dout holds an unaccepted word
- shift_en  output  1  shift strobe, = (state==DATA) && bit_tick (combinational)
- busy  output  1  state != IDLE
- frame_err  output  1  sticky: stop bit sampled low
- parity_err  output  1  sticky: parity mismatch (PARITY_EN=1 only)
- overrun  output  1  sticky: completed word dropped because dout still held

Behaviour:
- Reset: synchronous, active-low. Posedge clk with clear=0 sets state=IDLE, bit count=0, internal shift reg=0, dout=0, dout_valid=0, and all error flags=0. bit_tick, sin and dout_ready are ignored that cycle. Reset mid-frame aborts the frame and emits no word.
- States and transitions:
  - IDLE -> DATA on bit_tick && sin==0 (start bit). bit count <= 0.
  - IDLE stays on bit_tick && sin==1.
  - DATA: on each bit_tick, sh <= {sin, sh[WIDTH-1:1]} (shift right, new bit enters MSB) and count++. After WIDTH ticks go to PARITY if PARITY_EN=1, else STOP. count is ceil(log2(WIDTH+1)) bits and never wraps.
  - PARITY: on bit_tick, mismatch = (^sh) ^ sin. Even parity: the XOR of the data bits and the parity bit must be 0. Latch mismatch into a pending flag, then go to STOP.
  - STOP: on bit_tick:
    - sin==1: word is good. Raise parity_err if the pending flag is set; the word is delivered regardless of parity.
    - sin==0: frame_err <= 1. Discard the word; dout and dout_valid are unchanged.
    - Either way, go to IDLE.
- States change only on bit_tick. Cycles without a tick hold all state.
- Delivery on a good stop bit, registered (visible in the cycle after the stop-tick edge):
  - dout_valid==0, or dout_valid && dout_ready in the same cycle: dout <= sh, dout_valid <= 1.
  - dout_valid && !dout_ready: new word dropped, overrun <= 1, and the old dout is kept unchanged.
- Handshake:
  - dout and dout_valid hold until accepted.
  - dout_valid && dout_ready with no simultaneous load: dout_valid <= 0 next cycle, and dout keeps its value.
- Latency: dout_valid rises 1 clk after the rising edge at which the stop-bit tick is sampled.
- Error flags are sticky until err_clr or reset. If err_clr and a new error event occur in the same cycle, the new error wins and the flag stays 1.
- Back-to-back frames: a start bit may be sampled on the first tick after STOP exits to IDLE; no idle bit is required.

Test Plan:
1. WIDTH=4, PARITY_EN=0, dout_ready=1. Ticks every 8 clk, sin = 0 (start), then 1,0,1,1, then 1 (stop) -> dout=4'hD, dout_valid=1 for exactly 1 clk, starting 1 clk after the stop tick. shift_en pulses 4 times; busy high from the start tick through the stop tick; no error flags.
2. Same frame with stop bit = 0 -> frame_err=1, dout_valid stays 0, dout unchanged. Then err_clr pulse -> frame_err=0 next clk.
3. PARITY_EN=1, data 1,0,1,1:
   - parity bit 1, stop 1 -> dout=4'hD, parity_err=0.
   - parity bit 0 -> dout=4'hD delivered with parity_err=1.
4. dout_ready=0. Send 4'hD, then 4'h3 (bits 1,1,0,0) -> dout stays 4'hD, dout_valid=1, overrun=1. Then assert dout_ready -> dout_valid=0 next clk.
5. dout_valid=1 holding 4'hA. Assert dout_ready on the exact cycle the next stop tick completes 4'h5 -> dout=4'h5, dout_valid stays 1, overrun=0.
6. Drive clear=0 for 1 clk after the 2nd data bit of a frame -> next clk: busy=0, dout_valid=0, all flags=0. A following clean frame 4'h6 is received correctly.
